// File: rtl/genesis_pad_port_emu.sv
`default_nettype none
// ============================================================================
// genesis_pad_port_emu : Mega Drive 3/6-button pad pin emulation driven by TH.
// Optional build macro: GENPAD_MODE_FORCE3_EN (Mode held at reset -> 3-button)
// Revision: 1.0
// ============================================================================
module genesis_pad_port_emu #(
  parameter int TIMEOUT_CYCLES = 75000
) (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic [11:0] iPAD_DECODED,
  input  logic [1:0]  iPAD_TYPE,
  input  logic        iTH,
  output logic [5:0]  oPAD_DATA,
  output logic        oPAD_MODE6
);

  localparam int                  c_IDLE_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT_CYCLES - 1);

  logic                r_thQ;
  logic [2:0]          r_step;
  logic [c_IDLE_W-1:0] r_idle;
  logic                r_mode6;
  logic                w_thEdge;
  logic                w_force3;
  logic [11:0]         w_padN;
  logic [5:0]          w_padNext;

  assign w_thEdge = (iTH != r_thQ);
  assign w_padN   = ~iPAD_DECODED;

`ifdef GENPAD_MODE_FORCE3_EN
  logic r_force3;
  logic r_inReset;

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_force3  <= 1'b0;
      r_inReset <= 1'b1;
    end else begin
      r_inReset <= 1'b0;
      if (r_inReset && iPAD_DECODED[8]) r_force3 <= 1'b1;
    end
  end

  // Include the release cycle itself so mode6 never latches 1 before force3 lands.
  assign w_force3 = r_force3 | (r_inReset & iPAD_DECODED[8]);
`else
  assign w_force3 = 1'b0;
`endif

  // Index map: 11 Z, 10 Y, 9 X, 8 M, 7 S, 6 C, 5 B, 4 A, 3 U, 2 D, 1 L, 0 R.
  always_comb begin
    w_padNext = r_thQ ? {w_padN[6], w_padN[5], w_padN[0], w_padN[1], w_padN[2], w_padN[3]}
                      : {w_padN[7], w_padN[4], 2'b00, w_padN[2], w_padN[3]};
    if (r_mode6) begin
      if (!r_thQ && r_step == 3'd5)
        w_padNext = {w_padN[7], w_padN[4], 4'b0000};
      else if (r_thQ && r_step == 3'd6)
        w_padNext = {w_padN[6], w_padN[5], w_padN[8], w_padN[9], w_padN[10], w_padN[11]};
      else if (!r_thQ && r_step == 3'd7)
        w_padNext = {w_padN[7], w_padN[4], 4'b1111};
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_thQ      <= 1'b1;
      r_step     <= 3'd0;
      r_idle     <= '0;
      r_mode6    <= 1'b0;
      oPAD_DATA  <= 6'h3F;
      oPAD_MODE6 <= 1'b0;
    end else begin
      r_thQ <= iTH;
      // An edge wins over a coincident timeout; the idle count parks at its last value.
      if (w_thEdge) begin
        r_step <= r_step + 3'd1;
        r_idle <= '0;
      end else if (r_idle == c_IDLE_LAST) begin
        r_step <= r_thQ ? 3'd0 : 3'd1;
      end else begin
        r_idle <= r_idle + c_IDLE_W'(1);
      end
      if (r_step == 3'd0 && r_thQ)
        r_mode6 <= (iPAD_TYPE == 2'd2) && !w_force3;
      oPAD_DATA  <= w_padNext;
      oPAD_MODE6 <= r_mode6;
    end
  end

endmodule
`default_nettype wire
